// File: rtl/mmio_hub.sv
// MMIO hub between the core's data-memory port and the UART.
// Decodes a small register window at BASE. It holds the cycle and instruction
// counters, a counter-enable bit, and buffered UART TX/RX FIFOs.
// Load data is registered, so a read has the same one-cycle latency as DMEM.
`timescale 1ns/1ps

module mmio_hub_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    // The extra pointer MSB tells full apart from empty; the pointers wrap naturally.
    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Legality uses pre-edge occupancy, so a full FIFO refuses a push even while popping.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; reset discards any buffered bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; the contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

module mmio_hub #(
    parameter int               AWIDTH     = 32,
    parameter int               DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE      = 32'h8000_0000,
    parameter int               FIFO_DEPTH = 8,
    parameter int               CWIDTH     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr_in,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              we_in,
    input  logic              re_in,
    input  logic              inst_retire_in,
    output logic [DWIDTH-1:0] data_out,
    output logic [7:0]        uart_tx_data_out,
    output logic              uart_tx_valid_out,
    input  logic              uart_tx_ready_in,
    input  logic [7:0]        uart_rx_data_in,
    input  logic              uart_rx_valid_in,
    output logic              uart_rx_ready_out
);
    localparam logic [AWIDTH-1:0] A_STAT = BASE + AWIDTH'(8'h00);
    localparam logic [AWIDTH-1:0] A_RXD  = BASE + AWIDTH'(8'h04);
    localparam logic [AWIDTH-1:0] A_TXD  = BASE + AWIDTH'(8'h08);
    localparam logic [AWIDTH-1:0] A_CYC  = BASE + AWIDTH'(8'h10);
    localparam logic [AWIDTH-1:0] A_INST = BASE + AWIDTH'(8'h14);
    localparam logic [AWIDTH-1:0] A_CCLR = BASE + AWIDTH'(8'h18);
    localparam logic [AWIDTH-1:0] A_CEN  = BASE + AWIDTH'(8'h1C);

    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]        rx_head;
    logic [CWIDTH-1:0] cyc_cnt, inst_cnt;
    logic              en;
    logic [DWIDTH-1:0] rd_mux;
    logic              wr_tx, wr_clr, wr_en, rd_rx;
    logic              unused_data;

    // Strobes count only when the full address matches a register.
    assign wr_tx  = we_in && (addr_in == A_TXD);
    assign wr_clr = we_in && (addr_in == A_CCLR);
    assign wr_en  = we_in && (addr_in == A_CEN);
    assign rd_rx  = re_in && (addr_in == A_RXD);

    assign unused_data = ^data_in[DWIDTH-1:8];

    mmio_hub_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (uart_tx_ready_in),
        .din   (data_in[7:0]),
        .dout  (uart_tx_data_out),
        .empty (tx_empty),
        .full  (tx_full)
    );

    mmio_hub_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid_in && uart_rx_ready_out),
        .pop   (rd_rx),
        .din   (uart_rx_data_in),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign uart_tx_valid_out = !tx_empty;
    // Held low during reset so the receiver does not hand over a byte that would be dropped.
    assign uart_rx_ready_out = !rx_full && !rst;

    // Read mux over pre-edge state; unmapped and write-only offsets read 0.
    always_comb begin
        rd_mux = '0;
        if (addr_in == A_STAT)      rd_mux = DWIDTH'({!rx_empty, !tx_full});
        else if (addr_in == A_RXD)  rd_mux = rx_empty ? '0 : DWIDTH'(rx_head);
        else if (addr_in == A_CYC)  rd_mux = DWIDTH'(cyc_cnt);
        else if (addr_in == A_INST) rd_mux = DWIDTH'(inst_cnt);
        else if (addr_in == A_CEN)  rd_mux = DWIDTH'(en);
    end

    // Registered load data, held while no load is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data_out <= '0;
        else if (re_in) data_out <= rd_mux;
    end

    // Counters and enable; a clear wins over increment, and the enable write still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
            en       <= 1'b1;
        end else begin
            if (wr_en) en <= data_in[0];
            if (wr_clr) begin
                cyc_cnt  <= '0;
                inst_cnt <= '0;
            end else if (en) begin
                cyc_cnt <= cyc_cnt + CWIDTH'(1);
                if (inst_retire_in) inst_cnt <= inst_cnt + CWIDTH'(1);
            end
        end
    end
endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Parametrised successor to the core's MMIO decoder.
- Owns the cycle and instruction counters, a counter-enable register, and buffered UART TX/RX paths built from synchronous FIFOs.
- Sits between the core's data-memory port and the UART.
- Read data is registered, giving one-cycle latency that matches DMEM read timing.

Parameters:
- AWIDTH, 32, address width (>=32)
- DWIDTH, 32, data width (>=32)
- BASE, 32'h80000000, MMIO base address, zero-extended to AWIDTH
- FIFO_DEPTH, 8, entries per UART FIFO (power of two, >=2)
- CWIDTH, 32, counter width (<=DWIDTH)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- addr_in  input  AWIDTH  byte address from core
- data_in  input  DWIDTH  store data
- we_in  input  1  store strobe
- re_in  input  1  load strobe
- inst_retire_in  input  1  one instruction retired this cycle
- data_out  output  DWIDTH  registered load data
- uart_tx_data_out  output  8  byte to UART transmitter
- uart_tx_valid_out  output  1  TX byte available
- uart_tx_ready_in  input  1  transmitter accepts byte
- uart_rx_data_in  input  8  byte from UART receiver
- uart_rx_valid_in  input  1  receiver has byte
- uart_rx_ready_out  output  1  hub accepts RX byte

Behaviour:
- Address decode:
  - Compare the full addr_in against BASE+offset.
  - Unmapped addresses read 0; writes to them are ignored.
  - Ignore we_in and re_in unless the address matches.
- Register map (offset):
  - 0x00 status, RO: {0…, rx_nonempty, tx_notfull}.
  - 0x04 RX data, RO: {0…, head byte}. Reading pops the FIFO if it is non-empty. Reading when empty returns 0 with no pop.
  - 0x08 TX data, WO: pushes data_in[7:0] if TX not full. A write when full is dropped silently.
  - 0x10 cycle counter, RO, zero-extended.
  - 0x14 instruction counter, RO, zero-extended.
  - 0x18 counter reset, WO: any write clears both counters.
  - 0x1C counter enable, RW, bit0 only. Reads return {0…, en}.
- Read latency:
  - data_out is updated on the clk edge after re_in; it holds the value for the addressed register as sampled in the re_in cycle.
  - When re_in is low, data_out holds its previous value.
- Counters:
  - cycle increments every cycle while en=1.
  - inst increments when en=1 and inst_retire_in=1.
  - Both wrap modulo 2^CWIDTH.
  - A write to 0x18 takes priority over increment: next value is 0.
  - A simultaneous write to 0x1C and 0x18: both take effect.
- TX FIFO:
  - uart_tx_valid_out = !tx_empty; uart_tx_data_out = head.
  - Pop on valid&&ready.
- RX FIFO:
  - uart_rx_ready_out = !rx_full && !rst.
  - Push on valid&&ready.
- FIFO rules:
  - Pointer width is log2(FIFO_DEPTH)+1; the extra MSB distinguishes full from empty; pointers wrap naturally.
  - Simultaneous push and pop: both occur and occupancy is unchanged.
  - Push legality uses pre-edge occupancy, so a full FIFO rejects a push even when a pop happens the same cycle.
- Reset (asynchronous, immediate):
  - data_out=0, both FIFOs empty, counters=0, en=1.
  - Resulting outputs: tx_valid=0, rx_ready=0 while rst is high and 1 after release.
  - Reset mid-transfer discards FIFO contents.
- Status bits reflect pre-edge state in the cycle sampled.

Test Plan:
- Reset, then 10 idle cycles with en=1, then read 0x10 → data_out on the next cycle = 10 ±1 per documented sample point; 0x14 reads 0 with inst_retire_in=0.
- Hold uart_tx_ready_in=0 and write 0x41..0x48 to 0x08; a 9th write 0x49 is dropped and status bit0=0. Raise ready → bytes 0x41..0x48 appear in order, then tx_valid=0.
- Push 3 RX bytes 0x10,0x20,0x30; read 0x04 four times → 0x10,0x20,0x30,0; status bit1 is 0 after the third pop.
- Fill RX to 8 entries → rx_ready_out=0; one pop → rx_ready_out returns to 1 the next cycle. Simultaneous push/pop at 7 entries keeps occupancy at 7.
- Write 0 to 0x1C, run 20 cycles with inst_retire_in=1 → counters frozen. Write 0x18 → both read 0. Write 1 to 0x1C → counting resumes.
- Preload the cycle counter near 2^CWIDTH-1 via force (CWIDTH=8 build) → wraps to 0. Assert rst mid-TX-drain → tx_valid=0 and FIFO empty immediately.
